seq_decimalizer: RTL and testbench
==================================

Name: seq_decimalizer

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It is parametrised in input width and digit count and is driven by a start/busy/done handshake. It also reports overflow and a leading-zero blanking mask. It feeds the character renderer with decimal digits for option values, guess counters and highscores, so value fields are no longer limited to two digits.

Parameters:
W_IN, 11, binary input width in bits (1..16)
DIGITS, 4, number of BCD digits produced (1..5)
BLANK_LEADING, 1, 1 = digit_shown masks leading zeros; 0 = digit_shown is all ones

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  request conversion; sampled only while busy=0
value  in  W_IN  binary operand; captured on the accepted start cycle
busy  out  1  conversion in progress
done  out  1  one-cycle pulse; outputs valid from this cycle on
digits  out  [DIGITS-1:0][3:0]  BCD result; digits[0] = units
digit_shown  out  DIGITS  1 = renderer draws digit i; bit 0 is always 1
overflow  out  1  1 = value >= 10^DIGITS; digits then hold value mod 10^DIGITS

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, digits=all 0, digit_shown=1 (bit 0 only), overflow=0, internal shift/BCD registers 0.
- States:
  - IDLE: busy=0. If start=1, load value into the shift register, clear the BCD accumulator and the sticky overflow flag, set bit counter=W_IN, go to SHIFT.
  - SHIFT: busy=1. Each cycle, first add 3 to every BCD digit >= 5 (corrected digit stays 4 bits). Then shift {BCD, operand} left by 1 and decrement the counter. The bit shifted out of the top digit ORs into the sticky overflow flag. When the counter reaches 1 during this cycle, go to FINISH.
  - FINISH: busy=1. Register the accumulator to digits, compute digit_shown, register overflow, go to IDLE, and assert done in the following cycle.
- Latency: start sampled at cycle 0; done=1 and outputs updated at cycle W_IN+2; busy=1 for cycles 1..W_IN+1.
- done lasts exactly one cycle. digits, digit_shown and overflow hold stable until the next done.
- start while busy=1 is ignored; no queuing.
- start in the done cycle is accepted, because the block is in IDLE then; back-to-back throughput is W_IN+2 cycles.
- digit_shown[i] = 1 if i==0 or any digits[j], j>=i, is nonzero (with BLANK_LEADING=1). Overflow does not force extra bits.
- Counter width is $clog2(W_IN+1). Accumulator width is 4*DIGITS.
- Reset asserted mid-SHIFT aborts the conversion: no done, all outputs return to reset values at the next edge.
- value is sampled only at accept; later changes on value have no effect.

Decomposition:
- Shared package holds: typedef for a BCD digit (logic [3:0]); constant DEC_MAX_DIGITS=5; the existing per-field digit-length constants (LEN values), retyped to feed DIGITS.
- One sub-module: bcd_add3_digit, a combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times inside a generate loop.

Test Plan:
1. W_IN=11, DIGITS=4, value=1234, start pulse at cycle 0 -> busy 1..12, done at cycle 13, digits={1,2,3,4}, digit_shown=4'b1111, overflow=0.
2. value=0 -> digits={0,0,0,0}, digit_shown=4'b0001, overflow=0. value=7 -> digit_shown=4'b0001. value=40 -> digit_shown=4'b0011.
3. W_IN=11, DIGITS=3, value=2047 -> digits={0,4,7}, digit_shown=3'b011, overflow=1. value=999 -> digits={9,9,9}, overflow=0.
4. W_IN=8, DIGITS=2, value=99 -> {9,9}, overflow=0. Then start held high in the done cycle with value=100 -> accepted; next done 10 cycles later with {0,0}, overflow=1.
5. start pulsed again at cycle 5 of a running conversion with a different value -> ignored; done at cycle 13 reflects the first value only.
6. rst_n=0 for one cycle at cycle 6 of a conversion -> no done pulse, busy=0, digits=0, digit_shown=1 next cycle. A fresh start then converts normally.

Source files
------------

// File: rtl/seq_decimalizer_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Digit-length constants size the decimal fields handed to the character renderer.
package seq_decimalizer_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } dec_state_e;

    localparam int unsigned DEC_MAX_DIGITS = 5;

    // Per-field digit lengths; each is a legal DIGITS value for seq_decimalizer.
    localparam int unsigned LEN_OPTION    = 2;
    localparam int unsigned LEN_GUESS     = 3;
    localparam int unsigned LEN_HIGHSCORE = 4;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3_digit
    import seq_decimalizer_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/seq_decimalizer.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake,
// overflow reporting and leading-zero blanking mask.
module seq_decimalizer
    import seq_decimalizer_pkg::*;
#(
    parameter int unsigned W_IN          = 11,
    parameter int unsigned DIGITS        = 4,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [W_IN-1:0]        value,
    output logic                   busy,
    output logic                   done,
    output logic [DIGITS-1:0][3:0] digits,
    output logic [DIGITS-1:0]      digit_shown,
    output logic                   overflow
);

    localparam int unsigned CW = $clog2(W_IN + 1);
    localparam int unsigned AW = 4 * DIGITS;
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntLoad = CW'(W_IN);

    dec_state_e state_q, state_d;

    logic [W_IN-1:0]          shift_q;
    bcd_digit_t [DIGITS-1:0]  bcd_q;
    bcd_digit_t [DIGITS-1:0]  corr;
    logic [CW-1:0]            cnt_q;
    logic                     ovf_acc_q;
    logic [AW+W_IN-1:0]       shifted;

    bcd_digit_t [DIGITS-1:0]  digits_q;
    logic [DIGITS-1:0]        shown_q, shown_d;
    logic                     ovf_q;
    logic                     done_q;
    logic                     seen;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (bcd_q[g]),
            .dout (corr[g])
        );
    end

    assign shifted = {corr, shift_q} << 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StShift;
            StShift:  if (cnt_q == CntOne) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    // Digit i is drawn once any digit at or above it is nonzero; units always drawn.
    always_comb begin
        seen    = 1'b0;
        shown_d = '1;
        if (BLANK_LEADING) begin
            for (int i = DIGITS - 1; i >= 0; i--) begin
                seen       = seen | (bcd_q[i] != 4'd0);
                shown_d[i] = seen;
            end
            shown_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            digits_q  <= '0;
            shown_q   <= DIGITS'(1);
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == StFinish);
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q   <= value;
                        bcd_q     <= '0;
                        cnt_q     <= CntLoad;
                        ovf_acc_q <= 1'b0;
                    end
                end
                StShift: begin
                    {bcd_q, shift_q} <= shifted;
                    cnt_q            <= cnt_q - CntOne;
                    // A corrected top digit >= 8 carries out of the accumulator.
                    ovf_acc_q        <= ovf_acc_q | corr[DIGITS-1][3];
                end
                StFinish: begin
                    digits_q <= bcd_q;
                    shown_q  <= shown_d;
                    ovf_q    <= ovf_acc_q;
                end
                default: ;
            endcase
        end
    end

    assign done        = done_q;
    assign digits      = digits_q;
    assign digit_shown = shown_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_decimalizer.sv
// Directed bench for seq_decimalizer: three configurations (11/4, 11/3, 8/2) share clock and reset.
module tb_seq_decimalizer;

    logic clk = 1'b0;
    logic rst_n;

    logic        start_a, start_b, start_c;
    logic [10:0] val_a, val_b;
    logic [7:0]  val_c;

    logic            busy_a, done_a, ov_a;
    logic [3:0][3:0] dig_a;
    logic [3:0]      shown_a;
    logic            busy_b, done_b, ov_b;
    logic [2:0][3:0] dig_b;
    logic [2:0]      shown_b;
    logic            busy_c, done_c, ov_c;
    logic [1:0][3:0] dig_c;
    logic [1:0]      shown_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_decimalizer #(.W_IN(11), .DIGITS(4), .BLANK_LEADING(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .value(val_a), .busy(busy_a),
        .done(done_a), .digits(dig_a), .digit_shown(shown_a), .overflow(ov_a)
    );

    seq_decimalizer #(.W_IN(11), .DIGITS(3), .BLANK_LEADING(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .value(val_b), .busy(busy_b),
        .done(done_b), .digits(dig_b), .digit_shown(shown_b), .overflow(ov_b)
    );

    seq_decimalizer #(.W_IN(8), .DIGITS(2), .BLANK_LEADING(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .value(val_c), .busy(busy_c),
        .done(done_c), .digits(dig_c), .digit_shown(shown_c), .overflow(ov_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    // Called in cycle 0; returns in cycle 1 with start released.
    task automatic launch(input int sel, input int v);
        case (sel)
            0:       begin val_a = 11'(v); start_a = 1'b1; end
            1:       begin val_b = 11'(v); start_b = 1'b1; end
            default: begin val_c = 8'(v);  start_c = 1'b1; end
        endcase
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int cyc0, output int cyc, output bit busy_ok);
        cyc     = cyc0;
        busy_ok = 1'b1;
        while (!get_done(sel) && cyc < 40) begin
            if (!get_busy(sel)) busy_ok = 1'b0;
            step();
            cyc++;
        end
    endtask

    task automatic run(input int sel, input int v, input int lat, input string tag);
        int cyc;
        bit bok;
        launch(sel, v);
        wait_done(sel, 1, cyc, bok);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busy_during"}, bok, 1);
        check({tag, "_busy_at_done"}, get_busy(sel), 0);
    endtask

    initial begin
        int  cyc;
        bit  bok;
        bit  saw;
        rst_n   = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        val_a   = '0;   val_b   = '0;   val_c   = '0;
        step();
        step();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_digits", dig_a, 16'h0000);
        check("rst_shown", shown_a, 4'b0001);
        check("rst_ov", ov_a, 0);
        rst_n = 1'b1;
        step();

        // Test 1: basic conversion and done width
        run(0, 1234, 13, "a1234");
        check("a1234_digits", dig_a, 16'h1234);
        check("a1234_shown", shown_a, 4'b1111);
        check("a1234_ov", ov_a, 0);
        step();
        check("a1234_done_1cyc", done_a, 0);
        check("a1234_hold", dig_a, 16'h1234);

        // Test 2: leading-zero blanking
        run(0, 0, 13, "a0");
        check("a0_digits", dig_a, 16'h0000);
        check("a0_shown", shown_a, 4'b0001);
        check("a0_ov", ov_a, 0);
        run(0, 7, 13, "a7");
        check("a7_digits", dig_a, 16'h0007);
        check("a7_shown", shown_a, 4'b0001);
        run(0, 40, 13, "a40");
        check("a40_digits", dig_a, 16'h0040);
        check("a40_shown", shown_a, 4'b0011);

        // Test 3: three digits, overflow boundary
        run(1, 2047, 13, "b2047");
        check("b2047_digits", dig_b, 12'h047);
        check("b2047_shown", shown_b, 3'b011);
        check("b2047_ov", ov_b, 1);
        run(1, 999, 13, "b999");
        check("b999_digits", dig_b, 12'h999);
        check("b999_shown", shown_b, 3'b111);
        check("b999_ov", ov_b, 0);

        // Test 4: two digits, start accepted in the done cycle
        run(2, 99, 10, "c99");
        check("c99_digits", dig_c, 8'h99);
        check("c99_ov", ov_c, 0);
        val_c   = 8'd100;
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        check("c100_accepted", busy_c, 1);
        wait_done(2, 1, cyc, bok);
        check("c100_latency", cyc, 10);
        check("c100_busy_during", bok, 1);
        check("c100_digits", dig_c, 8'h00);
        check("c100_shown", shown_c, 2'b01);
        check("c100_ov", ov_c, 1);

        // Test 5: start while busy is ignored, value changes after accept ignored
        launch(0, 555);
        repeat (4) step();
        val_a   = 11'd999;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done(0, 6, cyc, bok);
        check("ign_latency", cyc, 13);
        check("ign_digits", dig_a, 16'h0555);
        check("ign_shown", shown_a, 4'b0111);
        step();
        check("ign_no_second_done", done_a, 0);
        check("ign_idle_after", busy_a, 0);

        // Test 6: reset mid-conversion aborts
        launch(0, 321);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_digits", dig_a, 16'h0000);
        check("abort_shown", shown_a, 4'b0001);
        rst_n = 1'b1;
        saw   = 1'b0;
        repeat (20) begin
            step();
            if (done_a || busy_a) saw = 1'b1;
        end
        check("abort_no_done", saw, 0);
        run(0, 321, 13, "a321");
        check("a321_digits", dig_a, 16'h0321);
        check("a321_shown", shown_a, 4'b0111);
        check("a321_ov", ov_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
